switch_output_scheduler: RTL and testbench
==========================================

Name: switch_output_scheduler

Overview:
- Per-output-port packet scheduler in the chiplet switch; one instance per switch output.
- Shares the output between WIDTH input buffers using round-robin arbitration at packet granularity (wormhole).
- The grant is held from head flit to tail flit. Flits pop from the winning input buffer only when downstream credits are available.
- Drives a registered flit onto the output link and tracks downstream buffer credits.

Parameters:
- WIDTH, 4, number of requesting input buffers (>=2)
- MAX_CREDITS, 8, downstream buffer depth in flits; credit counter reset value

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- bid  in  WIDTH  input i has a flit at its buffer head
- rdata  in  WIDTH x flit_t  head flit of each input buffer
- rlast  in  WIDTH  head flit of input i is a packet tail
- pop  out  WIDTH  one-hot combinational dequeue strobe to the input buffers
- out_valid  out  1  registered flit valid toward the downstream link
- out_flit  out  flit_t  registered flit
- credit_ret  in  1  downstream freed one flit slot this cycle
- busy  out  1  state == LOCKED
- credit_err  out  1  sticky; credit return while counter == MAX_CREDITS

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, select=0, last_winner=WIDTH-1 (input 0 has first priority).
  - credits=MAX_CREDITS, out_valid=0, out_flit=0, credit_err=0, pop=0.
- State IDLE:
  - If any bid bit is set, pick the first set bid strictly after last_winner, wrapping modulo WIDTH.
  - last_winner itself is eligible, with lowest priority.
  - Register select=winner; next state=LOCKED.
  - No pop and no flit is sent in the grant cycle. out_valid=0 the next cycle.
- State LOCKED, send condition bid[select] && credits!=0:
  - pop[select]=1 combinationally in the same cycle.
  - Next edge: out_flit<=rdata[select], out_valid<=1.
  - Credits decrement on that edge.
  - If rlast[select]=1: next state=IDLE, last_winner<=select.
- State LOCKED, otherwise:
  - pop=0; out_valid<=0 next edge; the grant is held and other bids are ignored.
  - A starving winner blocks the port; there is no timeout.
- Latency:
  - First flit appears at out_valid one cycle after the pop cycle, and two cycles after the first bid assertion into IDLE.
  - Back-to-back flits of one packet stream at 1 flit/cycle while credits last.
- Packet boundaries:
  - A packet that ends in IDLE needs one bubble cycle (the re-arbitration cycle) before the next packet starts.
  - A single-flit packet is head and tail at once: grant, then one pop, then back to IDLE.
- Credit counter:
  - Width $clog2(MAX_CREDITS+1).
  - Send and credit_ret in the same cycle leave it unchanged.
  - credit_ret alone increments it. At MAX_CREDITS it saturates and sets credit_err (sticky until RST).
  - At 0 the port stalls mid-packet and resumes the cycle after a credit_ret.
- Invariants: pop is at most one-hot; pop is never asserted in IDLE or when credits==0.
- Reset mid-packet: the packet is abandoned. The scheduler does not flush the input buffers; those are reset by the same RST.

Decomposition:
- Shared switch package holds:
  - flit_t
  - sched_state_e (IDLE, LOCKED)
  - a credit-width helper function
- Natural sub-module: rr_priority_pick.
  - Combinational.
  - Inputs: bid, last_winner. Outputs: winner index, found.
  - Reusable by other switch allocators.
- Credit counter stays inline.

Test Plan:
- Reset, then bid=4'b0001, rlast asserted on the 3rd flit, credits=8 → pop[0] for 3 consecutive cycles starting 1 cycle after the bid. out_valid high for 3 cycles, one cycle after each pop. credits end at 5. busy then drops.
- bid=4'b1111, every input sends 2-flit packets, credit_ret held high → grant order 0,1,2,3,0. Each packet is contiguous and there is one idle bubble between packets.
- Mid-packet interleave attempt: input 2 is locked and input 0 bids → no pop[0] until input 2's tail is sent; next winner is 3 if bidding, else 0.
- Credit stall:
  - Set MAX_CREDITS=2, send a 4-flit packet with no credit_ret → 2 flits sent, then pop=0 and out_valid=0.
  - Pulse credit_ret once → exactly one more flit sent, in the following cycle.
- Simultaneous send and credit_ret at credits=1 → counter stays 1 and streaming continues. credit_ret with the counter at MAX_CREDITS → credit_err=1 and the counter stays MAX_CREDITS.
- Assert RST mid-packet on input 1 → outputs drop to reset values asynchronously. After release, bid=4'b0010 re-arbitrates from IDLE with input 0 at top priority.

Source files
------------

// File: rtl/switch_output_scheduler_pkg.sv
// Shared switch definitions: flit type, scheduler state encoding and a
// helper that sizes credit counters for a given downstream buffer depth.
package switch_output_scheduler_pkg;

    localparam int FLIT_W = 32;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

    // Bits needed to hold every value from 0 up to max_credits inclusive.
    function automatic int credit_w(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
// Ports:
//   bid         - request vector, one bit per requester
//   last_winner - index of the previous winner (lowest priority this round)
//   winner      - first requester strictly after last_winner, wrapping
//   found       - at least one bid bit is set
module rr_priority_pick
    import switch_output_scheduler_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] bid,
    input  logic [IW-1:0]    last_winner,
    output logic [IW-1:0]    winner,
    output logic             found
);

    // Scan offsets 1..WIDTH so last_winner itself is visited last.
    always_comb begin : pick
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= WIDTH; k++) begin
            idx = (int'(last_winner) + k) % WIDTH;
            if (!found && bid[IW'(idx)]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/switch_output_scheduler.sv
// Per-output-port wormhole scheduler. Round-robin arbitrates between WIDTH
// input buffers at packet granularity, holds the grant from head to tail,
// pops flits only while downstream credits remain, and registers the flit
// onto the output link.
// Ports:
//   CLK, RST    - clock, asynchronous active-high reset
//   bid         - input i has a flit at its buffer head
//   rdata       - head flit of each input buffer
//   rlast       - head flit of input i is a packet tail
//   pop         - one-hot combinational dequeue strobe
//   out_valid   - registered flit valid toward downstream
//   out_flit    - registered flit
//   credit_ret  - downstream freed one flit slot
//   busy        - a packet grant is held
//   credit_err  - sticky: credit returned while counter was full
module switch_output_scheduler
    import switch_output_scheduler_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MAX_CREDITS = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [WIDTH-1:0]        bid,
    input  flit_t [WIDTH-1:0]       rdata,
    input  logic [WIDTH-1:0]        rlast,
    output logic [WIDTH-1:0]        pop,
    output logic                    out_valid,
    output flit_t                   out_flit,
    input  logic                    credit_ret,
    output logic                    busy,
    output logic                    credit_err
);

    localparam int             IW        = $clog2(WIDTH);
    localparam int             CW        = credit_w(MAX_CREDITS);
    localparam logic [CW-1:0]  CRED_MAX  = CW'(MAX_CREDITS);
    localparam logic [IW-1:0]  LAST_INIT = IW'(WIDTH - 1);

    sched_state_e  state, state_nxt;
    logic [IW-1:0] select, select_nxt;
    logic [IW-1:0] last_winner, last_winner_nxt;
    logic [CW-1:0] credits;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          send;

    rr_priority_pick #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_pick (
        .bid         (bid),
        .last_winner (last_winner),
        .winner      (pick_idx),
        .found       (pick_found)
    );

    // A flit moves only when locked, the winner has data, and downstream has room.
    assign send = (state == LOCKED) && bid[select] && (credits != '0);
    assign busy = (state == LOCKED);

    always_comb begin
        state_nxt       = state;
        select_nxt      = select;
        last_winner_nxt = last_winner;
        pop             = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt  = LOCKED;
                    select_nxt = pick_idx;
                end
            end
            LOCKED: begin
                if (send) begin
                    pop[select] = 1'b1;
                    if (rlast[select]) begin
                        state_nxt       = IDLE;
                        last_winner_nxt = select;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            select      <= '0;
            last_winner <= LAST_INIT;
        end else begin
            state       <= state_nxt;
            select      <= select_nxt;
            last_winner <= last_winner_nxt;
        end
    end

    // Output link register stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
        end else begin
            out_valid <= send;
            if (send) begin
                out_flit <= rdata[select];
            end
        end
    end

    // Simultaneous send and return cancel; a return into a full counter is
    // a downstream protocol error and is flagged rather than wrapped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            credits    <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            case ({send, credit_ret})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == CRED_MAX) begin
                        credit_err <= 1'b1;
                    end else begin
                        credits <= credits + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_output_scheduler.sv
module tb_switch_output_scheduler;
    import switch_output_scheduler_pkg::*;

    localparam flit_t FA = 32'hA000_0000;
    localparam flit_t FB = 32'hB000_0000;
    localparam flit_t FC = 32'hC000_0000;
    localparam flit_t FD = 32'hD000_0000;

    logic             CLK, RST;
    logic [3:0]       bid, rlast, pop;
    flit_t [3:0]      rdata;
    logic             out_valid, credit_ret, busy, credit_err;
    flit_t            out_flit;

    logic [3:0]       bid2, rlast2, pop2;
    flit_t [3:0]      rdata2;
    logic             out_valid2, credit_ret2, busy2, credit_err2;
    flit_t            out_flit2;

    int errs   = 0;
    int checks = 0;

    switch_output_scheduler #(.WIDTH(4), .MAX_CREDITS(8)) dut (
        .CLK(CLK), .RST(RST), .bid(bid), .rdata(rdata), .rlast(rlast),
        .pop(pop), .out_valid(out_valid), .out_flit(out_flit),
        .credit_ret(credit_ret), .busy(busy), .credit_err(credit_err)
    );

    switch_output_scheduler #(.WIDTH(4), .MAX_CREDITS(2)) dut2 (
        .CLK(CLK), .RST(RST), .bid(bid2), .rdata(rdata2), .rlast(rlast2),
        .pop(pop2), .out_valid(out_valid2), .out_flit(out_flit2),
        .credit_ret(credit_ret2), .busy(busy2), .credit_err(credit_err2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bid = '0; rlast = '0; rdata = '0; credit_ret = 1'b0;
        bid2 = '0; rlast2 = '0; rdata2 = '0; credit_ret2 = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b0;
        #1 RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        #2;
        checks++; if (pop !== 4'b0000) begin errs++; $display("FAIL reset_pop got=%b exp=0000", pop); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_flit !== 32'h0) begin errs++; $display("FAIL reset_out_flit got=%h exp=0", out_flit); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (credit_err !== 1'b0) begin errs++; $display("FAIL reset_credit_err got=%b exp=0", credit_err); end
        checks++; if (dut.credits !== 4'd8) begin errs++; $display("FAIL reset_credits got=%0d exp=8", dut.credits); end
    endtask

    // Input 0 sends a 3-flit packet with full credits.
    task automatic test_single_packet();
        logic [3:0] exp_pop [6] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        logic       exp_ov  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cycle();
            bid      = (c <= 3) ? 4'b0001 : 4'b0000;
            rdata[0] = FA + flit_t'(c);
            rlast[0] = (c == 3);
            #2;
            checks++; if (pop !== exp_pop[c]) begin errs++; $display("FAIL pkt_pop c%0d got=%b exp=%b", c, pop, exp_pop[c]); end
            checks++; if (out_valid !== exp_ov[c]) begin errs++; $display("FAIL pkt_out_valid c%0d got=%b exp=%b", c, out_valid, exp_ov[c]); end
            if (exp_ov[c]) begin
                checks++; if (out_flit !== FA + flit_t'(c - 1)) begin errs++; $display("FAIL pkt_out_flit c%0d got=%h exp=%h", c, out_flit, FA + flit_t'(c - 1)); end
            end
        end
        checks++; if (dut.credits !== 4'd5) begin errs++; $display("FAIL pkt_credits got=%0d exp=5", dut.credits); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL pkt_busy got=%b exp=0", busy); end
    endtask

    // All inputs bid with 2-flit packets; grants rotate 0,1,2,3,0 with a bubble each.
    task automatic test_round_robin();
        int         order [5] = '{0, 1, 2, 3, 0};
        int         cnt   [4] = '{0, 0, 0, 0};
        logic [3:0] exp;
        logic       prev_valid;
        flit_t      prev_flit;
        int         g;
        do_reset();
        prev_valid = 1'b0;
        prev_flit  = '0;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) next_cycle();
            bid        = 4'b1111;
            credit_ret = 1'b1;
            for (int i = 0; i < 4; i++) begin
                rlast[i] = (cnt[i] == 1);
                rdata[i] = FB | flit_t'(i << 4) | flit_t'(cnt[i]);
            end
            #2;
            g   = order[k / 3];
            exp = (k % 3 == 0) ? 4'b0000 : 4'(1 << g);
            checks++; if (pop !== exp) begin errs++; $display("FAIL rr_pop k%0d got=%b exp=%b", k, pop, exp); end
            checks++; if (out_valid !== prev_valid) begin errs++; $display("FAIL rr_out_valid k%0d got=%b exp=%b", k, out_valid, prev_valid); end
            if (prev_valid) begin
                checks++; if (out_flit !== prev_flit) begin errs++; $display("FAIL rr_out_flit k%0d got=%h exp=%h", k, out_flit, prev_flit); end
            end
            prev_valid = (exp != 4'b0000);
            if (prev_valid) begin
                prev_flit = rdata[g];
                cnt[g]    = (cnt[g] == 1) ? 0 : cnt[g] + 1;
            end
        end
    endtask

    // Input 2 is locked; inputs 0 and 3 bid mid-packet and must wait.
    task automatic test_no_interleave();
        logic [3:0] exp_pop [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cycle();
            bid      = (c == 0) ? 4'b0100 : 4'b1101;
            rdata[2] = FB + flit_t'(c);
            rlast[2] = (c == 3);
            #2;
            checks++; if (pop !== exp_pop[c]) begin errs++; $display("FAIL lock_pop c%0d got=%b exp=%b", c, pop, exp_pop[c]); end
        end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL lock_busy got=%b exp=1", busy); end
    endtask

    // MAX_CREDITS=2 instance: stall, single-credit resume, cancel, overflow error.
    task automatic test_credits();
        logic       t_bid [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        logic       t_cr  [12] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 0};
        logic       t_rl  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        logic       t_pop [12] = '{0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
        logic       t_ov  [12] = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c > 0) next_cycle();
            bid2        = {3'b000, t_bid[c]};
            credit_ret2 = t_cr[c];
            rlast2[0]   = t_rl[c];
            rdata2[0]   = FC + flit_t'(c);
            #2;
            checks++; if (pop2 !== {3'b000, t_pop[c]}) begin errs++; $display("FAIL cr_pop c%0d got=%b exp=%b", c, pop2, {3'b000, t_pop[c]}); end
            checks++; if (out_valid2 !== t_ov[c]) begin errs++; $display("FAIL cr_out_valid c%0d got=%b exp=%b", c, out_valid2, t_ov[c]); end
            if (t_ov[c]) begin
                checks++; if (out_flit2 !== FC + flit_t'(c - 1)) begin errs++; $display("FAIL cr_out_flit c%0d got=%h exp=%h", c, out_flit2, FC + flit_t'(c - 1)); end
            end
            if (c == 4) begin
                checks++; if (dut2.credits !== 2'd0) begin errs++; $display("FAIL cr_stall_credits got=%0d exp=0", dut2.credits); end
            end
            if (c == 9) begin
                checks++; if (dut2.credits !== 2'd1) begin errs++; $display("FAIL cr_cancel_credits got=%0d exp=1", dut2.credits); end
                checks++; if (busy2 !== 1'b0) begin errs++; $display("FAIL cr_busy got=%b exp=0", busy2); end
            end
            if (c == 10) begin
                checks++; if (credit_err2 !== 1'b0) begin errs++; $display("FAIL cr_err_early got=%b exp=0", credit_err2); end
            end
            if (c == 11) begin
                checks++; if (credit_err2 !== 1'b1) begin errs++; $display("FAIL cr_err got=%b exp=1", credit_err2); end
                checks++; if (dut2.credits !== 2'd2) begin errs++; $display("FAIL cr_sat_credits got=%0d exp=2", dut2.credits); end
            end
        end
    endtask

    // Reset asserted mid-packet on input 1, then re-arbitration from IDLE.
    task automatic test_reset_mid_packet();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) next_cycle();
            bid      = 4'b0010;
            rdata[1] = FD + flit_t'(c);
            #2;
        end
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
        RST = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_flit !== 32'h0) begin errs++; $display("FAIL mid_rst_flit got=%h exp=0", out_flit); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (pop !== 4'b0000) begin errs++; $display("FAIL mid_rst_pop got=%b exp=0000", pop); end
        checks++; if (dut.credits !== 4'd8) begin errs++; $display("FAIL mid_rst_credits got=%0d exp=8", dut.credits); end
        clear_inputs();
        next_cycle();
        RST = 1'b0;
        bid = 4'b0010;
        rdata[1] = FD + 32'h10;
        #2;
        checks++; if (pop !== 4'b0000) begin errs++; $display("FAIL mid_regrant_pop got=%b exp=0000", pop); end
        next_cycle();
        #2;
        checks++; if (pop !== 4'b0010) begin errs++; $display("FAIL mid_first_pop got=%b exp=0010", pop); end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy got=%b exp=1", busy); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_no_interleave();
        test_credits();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
